io_stream_run_monitor: RTL and testbench

//  Synthesizable run controller and output-stream monitor for an HLS kernel with NUM_CH output FIFOs.

---
 rtl/io_stream_run_monitor.sv | 169 ++++++++++++++++
 tb/tb_io_stream_run_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_stream_run_monitor.sv
// Run controller and per-channel output-stream monitor (saturating word count + rotate-XOR checksum) for an HLS kernel.
// Optional RUN watchdog is compiled in by defining STREAM_MON_TIMEOUT_EN.
module io_stream_run_monitor #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned RUN_W      = 6,
   parameter int unsigned MAX_RUNS   = 2,
   parameter int unsigned GAP_CYCLES = 16
`ifdef STREAM_MON_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT    = 2**20
`endif
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic                     en,
   output logic                     ap_start,
   input  logic                     ap_done,
   input  logic [NUM_CH-1:0]        ch_write,
   input  logic [NUM_CH*DATA_W-1:0] ch_din,
   output logic [NUM_CH*CNT_W-1:0]  res_cnt,
   output logic [NUM_CH*DATA_W-1:0] res_csum,
   output logic                     res_valid,
   output logic [RUN_W-1:0]         run_cnt,
   output logic                     all_done,
   output logic                     timeout_err
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [RUN_W-1:0]  run_cnt_q, run_cnt_d, run_cnt_inc;
   logic              res_valid_q, res_valid_d;
   logic              start_run;
   logic [CNT_W-1:0]  acc_cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  acc_cnt_d  [NUM_CH];
   logic [DATA_W-1:0] acc_csum_q [NUM_CH];
   logic [DATA_W-1:0] acc_csum_d [NUM_CH];
   logic [CNT_W-1:0]  res_cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  res_cnt_d  [NUM_CH];
   logic [DATA_W-1:0] res_csum_q [NUM_CH];
   logic [DATA_W-1:0] res_csum_d [NUM_CH];

`ifdef STREAM_MON_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              timeout_err_q, timeout_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      run_cnt_d   = run_cnt_q;
      run_cnt_inc = run_cnt_q + RUN_W'(1);
      res_valid_d = 1'b0;
      start_run   = 1'b0;
      acc_cnt_d   = acc_cnt_q;
      acc_csum_d  = acc_csum_q;
      res_cnt_d   = res_cnt_q;
      res_csum_d  = res_csum_q;
`ifdef STREAM_MON_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = timeout_err_q;
`endif
      unique case (state_q)
         S_IDLE: start_run = en;
         S_RUN: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (ch_write[i]) begin
                  if (acc_cnt_q[i] != '1) acc_cnt_d[i] = acc_cnt_q[i] + CNT_W'(1);
                  acc_csum_d[i] = {acc_csum_q[i][DATA_W-2:0], acc_csum_q[i][DATA_W-1]}
                                  ^ ch_din[i*DATA_W +: DATA_W];
               end
            end
`ifdef STREAM_MON_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
            // Results take the post-update values so a write coinciding with ap_done belongs to this run.
            if (ap_done) begin
               res_cnt_d   = acc_cnt_d;
               res_csum_d  = acc_csum_d;
               res_valid_d = 1'b1;
               run_cnt_d   = run_cnt_inc;
               gap_cnt_d   = '0;
               state_d     = (run_cnt_inc == RUN_W'(MAX_RUNS)) ? S_DONE : S_GAP;
            end
`ifdef STREAM_MON_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               timeout_err_d = 1'b1;
               state_d       = S_DONE;
            end
`endif
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               gap_cnt_d = '0;
               start_run = en;
               if (!en) state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      if (start_run) begin
         state_d = S_RUN;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_cnt_d[i]  = '0;
            acc_csum_d[i] = '0;
         end
`ifdef STREAM_MON_TIMEOUT_EN
         tmo_cnt_d = '0;
`endif
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= S_IDLE;
         gap_cnt_q   <= '0;
         run_cnt_q   <= '0;
         res_valid_q <= 1'b0;
         acc_cnt_q   <= '{default: '0};
         acc_csum_q  <= '{default: '0};
         res_cnt_q   <= '{default: '0};
         res_csum_q  <= '{default: '0};
`ifdef STREAM_MON_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         run_cnt_q   <= run_cnt_d;
         res_valid_q <= res_valid_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_csum_q  <= acc_csum_d;
         res_cnt_q   <= res_cnt_d;
         res_csum_q  <= res_csum_d;
`ifdef STREAM_MON_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign ap_start  = (state_q == S_RUN);
   assign all_done  = (state_q == S_DONE);
   assign res_valid = res_valid_q;
   assign run_cnt   = run_cnt_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign res_cnt[g*CNT_W +: CNT_W]    = res_cnt_q[g];
      assign res_csum[g*DATA_W +: DATA_W] = res_csum_q[g];
   end

`ifdef STREAM_MON_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_io_stream_run_monitor.sv
// Randomized bench for io_stream_run_monitor against a queue-based per-run model of counts and checksums.
module tb_io_stream_run_monitor;

   localparam int NUM_CH     = 4;
   localparam int DATA_W     = 32;
   localparam int CNT_W      = 4;
   localparam int RUN_W      = 6;
   localparam int MAX_RUNS   = 3;
   localparam int GAP_CYCLES = 16;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef STREAM_MON_TIMEOUT_EN
   localparam int TMO        = 100;
`endif

   logic                     ap_clk = 1'b0;
   logic                     ap_rst;
   logic                     en;
   logic                     ap_start;
   logic                     ap_done;
   logic [NUM_CH-1:0]        ch_write;
   logic [NUM_CH*DATA_W-1:0] ch_din;
   logic [NUM_CH*CNT_W-1:0]  res_cnt;
   logic [NUM_CH*DATA_W-1:0] res_csum;
   logic                     res_valid;
   logic [RUN_W-1:0]         run_cnt;
   logic                     all_done;
   logic                     timeout_err;

   io_stream_run_monitor #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .RUN_W(RUN_W),
      .MAX_RUNS(MAX_RUNS), .GAP_CYCLES(GAP_CYCLES)
`ifdef STREAM_MON_TIMEOUT_EN
      , .TIMEOUT(TMO)
`endif
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .en(en), .ap_start(ap_start), .ap_done(ap_done),
      .ch_write(ch_write), .ch_din(ch_din), .res_cnt(res_cnt), .res_csum(res_csum),
      .res_valid(res_valid), .run_cnt(run_cnt), .all_done(all_done), .timeout_err(timeout_err)
   );

   always #5 ap_clk = ~ap_clk;

   // Model: words accepted per channel in the current run, plus the last expected results.
   logic [DATA_W-1:0] mq [NUM_CH][$];
   logic [CNT_W-1:0]  exp_cnt  [NUM_CH];
   logic [DATA_W-1:0] exp_csum [NUM_CH];
   int runs_m;
   int n_checks;
   int n_fail;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DATA_W-1:0] model_csum(input int ch);
      logic [DATA_W-1:0] a;
      a = '0;
      for (int k = 0; k < mq[ch].size(); k++)
         a = ((a << 1) | (a >> (DATA_W - 1))) ^ mq[ch][k];
      return a;
   endfunction

   task automatic check_res(input string pfx);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         check($sformatf("%s_cnt%0d", pfx, ch), 64'(res_cnt[ch*CNT_W +: CNT_W]), 64'(exp_cnt[ch]));
         check($sformatf("%s_csum%0d", pfx, ch), 64'(res_csum[ch*DATA_W +: DATA_W]), 64'(exp_csum[ch]));
      end
   endtask

   task automatic drive_junk();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         ch_write[ch] = 1'($urandom_range(0, 1));
         ch_din[ch*DATA_W +: DATA_W] = $urandom();
      end
      ap_done = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      ap_rst = 1'b1; en = 1'b1; ap_done = 1'b0; ch_write = '0; ch_din = '0;
      repeat (2) @(negedge ap_clk);
      runs_m = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         exp_cnt[ch] = '0; exp_csum[ch] = '0; mq[ch].delete();
      end
      check("rst_ap_start", 64'(ap_start), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_run_cnt", 64'(run_cnt), 64'd0);
      check("rst_all_done", 64'(all_done), 64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      check_res("rst");
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("rst_release_start", 64'(ap_start), 64'd1);
   endtask

   // mode 0: random writes; 1: all channels every cycle; 2: ch1 every cycle; 3: ch0 only with data 1,2,3...
   task automatic do_run(input int len, input int mode);
      check("run_entry_start", 64'(ap_start), 64'd1);
      for (int ch = 0; ch < NUM_CH; ch++) mq[ch].delete();
      for (int c = 0; c < len; c++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            logic w;
            logic [DATA_W-1:0] d;
            d = $urandom();
            case (mode)
               1:       w = 1'b1;
               2:       w = (ch == 1) ? 1'b1 : 1'($urandom_range(0, 1));
               3: begin w = (ch == 0); d = DATA_W'(c + 1); end
               default: w = 1'($urandom_range(0, 1));
            endcase
            ch_write[ch] = w;
            ch_din[ch*DATA_W +: DATA_W] = d;
            if (w) mq[ch].push_back(d);
         end
         ap_done = (c == len - 1);
         @(negedge ap_clk);
      end
      ch_write = '0; ap_done = 1'b0;
      runs_m++;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         int n;
         n = mq[ch].size();
         exp_cnt[ch]  = CNT_W'((n > CNT_MAX) ? CNT_MAX : n);
         exp_csum[ch] = model_csum(ch);
      end
      check("run_res_valid", 64'(res_valid), 64'd1);
      check_res("run");
      check("run_run_cnt", 64'(run_cnt), 64'(runs_m));
      check("run_start_off", 64'(ap_start), 64'd0);
      check("run_all_done", 64'(all_done), 64'(runs_m == MAX_RUNS));
      check("run_timeout_err", 64'(timeout_err), 64'd0);
   endtask

   task automatic gap_phase(input logic en_v);
      int   low;
      logic rv_bad;
      low = 0; rv_bad = 1'b0;
      en = en_v;
      while (ap_start == 1'b0 && low < 40) begin
         if (low > 0 && res_valid) rv_bad = 1'b1;
         low++;
         drive_junk();
         @(negedge ap_clk);
      end
      ch_write = '0; ap_done = 1'b0;
      check("gap_res_valid_once", 64'(rv_bad), 64'd0);
      check("gap_run_cnt", 64'(run_cnt), 64'(runs_m));
      check_res("gap");
      if (en_v) begin
         check("gap_len", 64'(low), 64'(GAP_CYCLES));
      end else begin
         check("idle_hold", 64'(low), 64'd40);
         en = 1'b1;
         @(negedge ap_clk);
         check("idle_to_run", 64'(ap_start), 64'd1);
      end
   endtask

   task automatic done_phase();
      logic start_seen, rv_seen, done_low;
      start_seen = 1'b0; rv_seen = 1'b0; done_low = 1'b0;
      en = 1'b1;
      for (int c = 0; c < 20; c++) begin
         drive_junk();
         @(negedge ap_clk);
         if (ap_start)  start_seen = 1'b1;
         if (res_valid) rv_seen = 1'b1;
         if (!all_done) done_low = 1'b1;
      end
      ch_write = '0; ap_done = 1'b0;
      check("done_start_stays_low", 64'(start_seen), 64'd0);
      check("done_no_res_valid", 64'(rv_seen), 64'd0);
      check("done_all_done_sticky", 64'(done_low), 64'd0);
      check("done_run_cnt", 64'(run_cnt), 64'(MAX_RUNS));
      check_res("done");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_fail = 0; runs_m = 0;
      do_reset();

      do_run(3, 3);
      check("ch0_123_csum_literal", 64'(res_csum[DATA_W-1:0]), 64'h3);
      gap_phase(1'b1);
      do_run(10, 1);
      gap_phase(1'b1);
      do_run(20, 2);
      done_phase();

      // Reset in the middle of a run.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive_junk();
         ap_done = 1'b0;
         @(negedge ap_clk);
      end
      ap_rst = 1'b1; ch_write = '0;
      @(negedge ap_clk);
      check("midrun_rst_start", 64'(ap_start), 64'd0);
      check("midrun_rst_run_cnt", 64'(run_cnt), 64'd0);
      do_reset();
      do_run(5, 0);

      for (int r = 0; r < 3; r++) begin
         do_reset();
         while (runs_m < MAX_RUNS) begin
            do_run($urandom_range(1, 40), 0);
            if (runs_m < MAX_RUNS) gap_phase(1'($urandom_range(0, 1)));
         end
         done_phase();
      end

`ifdef STREAM_MON_TIMEOUT_EN
      begin : tmo_blk
         int   n;
         logic rv;
         n = 0; rv = 1'b0;
         do_reset();
         while (ap_start && n < 300) begin
            if (res_valid) rv = 1'b1;
            n++;
            @(negedge ap_clk);
         end
         check("tmo_run_len", 64'(n), 64'(TMO));
         check("tmo_timeout_err", 64'(timeout_err), 64'd1);
         check("tmo_all_done", 64'(all_done), 64'd1);
         check("tmo_start_low", 64'(ap_start), 64'd0);
         check("tmo_run_cnt", 64'(run_cnt), 64'd0);
         check("tmo_no_res_valid", 64'(rv | res_valid), 64'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
